// File: rtl/serial_rx_fifo.sv
// Receive-side byte FIFO behind the UART receiver.
// First-word-fall-through head register, overrun flag, framing-error counter.
module serial_rx_fifo #(
  parameter int Depth        = 16,
  parameter int AlmostFullAt = 12
) (
  input  logic                       iClock,
  input  logic                       iReset_n,
  input  logic [7:0]                 iData,
  input  logic                       iReceived,
  input  logic                       iError,
  output logic [7:0]                 oData,
  output logic                       oValid,
  input  logic                       iReady,
  output logic [$clog2(Depth):0]     oCount,
  output logic                       oAlmostFull,
  output logic                       oOverrun,
  output logic [7:0]                 oErrorCount,
  input  logic                       iClearFlags
);

  localparam int PtrW = $clog2(Depth);
  localparam int CntW = PtrW + 1;

  logic [7:0]      mem [Depth];
  logic [PtrW-1:0] wrPtr;
  logic [PtrW-1:0] rdPtr;
  logic [PtrW-1:0] rdNext;
  logic [CntW-1:0] count;
  logic [7:0]      headQ;
  logic            full;
  logic            empty;
  logic            push;
  logic            pop;
  logic            drop;

  assign full   = (count == CntW'(Depth));
  assign empty  = (count == '0);
  assign pop    = ~empty & iReady;
  assign push   = iReceived & (~full | pop);
  assign drop   = iReceived & full & ~pop;
  assign rdNext = rdPtr + PtrW'(1);

  assign oData       = headQ;
  assign oValid      = ~empty;
  assign oCount      = count;
  assign oAlmostFull = (count >= CntW'(AlmostFullAt));

  // Storage array; the slot being written is never the next head read.
  always_ff @(posedge iClock) begin
    if (push) begin
      mem[wrPtr] <= iData;
    end
  end

  // Write pointer advances on every accepted byte.
  always_ff @(posedge iClock or negedge iReset_n) begin
    if (!iReset_n) begin
      wrPtr <= '0;
    end else if (push) begin
      wrPtr <= wrPtr + PtrW'(1);
    end
  end

  // Read pointer advances on every consumer pop.
  always_ff @(posedge iClock or negedge iReset_n) begin
    if (!iReset_n) begin
      rdPtr <= '0;
    end else if (pop) begin
      rdPtr <= rdNext;
    end
  end

  // Occupancy: +1 push only, -1 pop only, else hold.
  always_ff @(posedge iClock or negedge iReset_n) begin
    if (!iReset_n) begin
      count <= '0;
    end else if (push && !pop) begin
      count <= count + CntW'(1);
    end else if (pop && !push) begin
      count <= count - CntW'(1);
    end
  end

  // Head register: loads on empty->non-empty or on a pop exposing a new head.
  always_ff @(posedge iClock or negedge iReset_n) begin
    if (!iReset_n) begin
      headQ <= 8'h00;
    end else if (empty) begin
      if (push) begin
        headQ <= iData;
      end
    end else if (pop) begin
      if (count > CntW'(1)) begin
        headQ <= mem[rdNext];
      end else if (push) begin
        headQ <= iData;
      end
    end
  end

  // Sticky overrun; a new drop beats a same-cycle clear.
  always_ff @(posedge iClock or negedge iReset_n) begin
    if (!iReset_n) begin
      oOverrun <= 1'b0;
    end else if (drop) begin
      oOverrun <= 1'b1;
    end else if (iClearFlags) begin
      oOverrun <= 1'b0;
    end
  end

  // Saturating framing-error counter; a new error beats a same-cycle clear.
  always_ff @(posedge iClock or negedge iReset_n) begin
    if (!iReset_n) begin
      oErrorCount <= 8'h00;
    end else if (iError) begin
      if (iClearFlags) begin
        oErrorCount <= 8'h01;
      end else if (oErrorCount != 8'hFF) begin
        oErrorCount <= oErrorCount + 8'h01;
      end
    end else if (iClearFlags) begin
      oErrorCount <= 8'h00;
    end
  end

endmodule

// File: tb/tb_serial_rx_fifo.sv
// Directed self-checking bench for serial_rx_fifo.
// One task per scenario, expectations hand-computed.
module tb_serial_rx_fifo;

  logic       iClock;
  logic       iReset_n;
  logic [7:0] iData;
  logic       iReceived;
  logic       iError;
  logic [7:0] oData;
  logic       oValid;
  logic       iReady;
  logic [4:0] oCount;
  logic       oAlmostFull;
  logic       oOverrun;
  logic [7:0] oErrorCount;
  logic       iClearFlags;

  int checks;
  int failures;

  serial_rx_fifo #(.Depth(16), .AlmostFullAt(12)) dut (
    .iClock      (iClock),
    .iReset_n    (iReset_n),
    .iData       (iData),
    .iReceived   (iReceived),
    .iError      (iError),
    .oData       (oData),
    .oValid      (oValid),
    .iReady      (iReady),
    .oCount      (oCount),
    .oAlmostFull (oAlmostFull),
    .oOverrun    (oOverrun),
    .oErrorCount (oErrorCount),
    .iClearFlags (iClearFlags)
  );

  initial iClock = 1'b0;
  always #5 iClock = ~iClock;

  task automatic tick();
    @(posedge iClock);
    #1;
  endtask

  task automatic fill16(input logic [7:0] base);
    iReady = 1'b0;
    for (int i = 0; i < 16; i++) begin
      iData = base + 8'(i);
      iReceived = 1'b1;
      tick();
    end
    iReceived = 1'b0;
  endtask

  task automatic test_reset();
    iReset_n = 1'b0;
    iData = 8'h00;
    iReceived = 1'b0;
    iError = 1'b0;
    iReady = 1'b0;
    iClearFlags = 1'b0;
    tick();
    tick();
    iReset_n = 1'b1;
    tick();
    checks++;
    if (oValid !== 1'b0 || oCount !== 5'd0 || oData !== 8'h00) begin
      failures++;
      $display("FAIL reset_fifo valid=%b count=%0d data=%h want 0 0 00",
               oValid, oCount, oData);
    end
    checks++;
    if (oAlmostFull !== 1'b0 || oOverrun !== 1'b0 || oErrorCount !== 8'h00) begin
      failures++;
      $display("FAIL reset_flags af=%b ovr=%b err=%0d want 0 0 0",
               oAlmostFull, oOverrun, oErrorCount);
    end
  endtask

  task automatic test_single();
    iData = 8'hA5;
    iReceived = 1'b1;
    tick();
    iReceived = 1'b0;
    checks++;
    if (oValid !== 1'b1 || oData !== 8'hA5 || oCount !== 5'd1) begin
      failures++;
      $display("FAIL single_push valid=%b data=%h count=%0d want 1 a5 1",
               oValid, oData, oCount);
    end
    tick();
    checks++;
    if (oValid !== 1'b1 || oData !== 8'hA5) begin
      failures++;
      $display("FAIL single_hold valid=%b data=%h want 1 a5", oValid, oData);
    end
    iReady = 1'b1;
    tick();
    iReady = 1'b0;
    checks++;
    if (oValid !== 1'b0 || oCount !== 5'd0) begin
      failures++;
      $display("FAIL single_pop valid=%b count=%0d want 0 0", oValid, oCount);
    end
  endtask

  task automatic test_fill_drain();
    iReady = 1'b0;
    for (int i = 0; i < 16; i++) begin
      iData = 8'(i);
      iReceived = 1'b1;
      tick();
      checks++;
      if (oCount !== 5'(i + 1) || oAlmostFull !== (i + 1 >= 12)) begin
        failures++;
        $display("FAIL fill_count i=%0d count=%0d af=%b want %0d %b",
                 i, oCount, oAlmostFull, i + 1, (i + 1 >= 12));
      end
    end
    iReceived = 1'b0;
    checks++;
    if (oOverrun !== 1'b0 || oData !== 8'h00) begin
      failures++;
      $display("FAIL fill_flags ovr=%b head=%h want 0 00", oOverrun, oData);
    end
    iReady = 1'b1;
    for (int i = 0; i < 16; i++) begin
      checks++;
      if (oValid !== 1'b1 || oData !== 8'(i)) begin
        failures++;
        $display("FAIL drain_order i=%0d valid=%b data=%h want 1 %h",
                 i, oValid, oData, 8'(i));
      end
      tick();
    end
    iReady = 1'b0;
    checks++;
    if (oValid !== 1'b0 || oCount !== 5'd0) begin
      failures++;
      $display("FAIL drain_empty valid=%b count=%0d want 0 0", oValid, oCount);
    end
  endtask

  task automatic test_overrun();
    fill16(8'h00);
    iData = 8'hEE;
    iReceived = 1'b1;
    tick();
    iReceived = 1'b0;
    checks++;
    if (oOverrun !== 1'b1 || oCount !== 5'd16) begin
      failures++;
      $display("FAIL overrun_drop ovr=%b count=%0d want 1 16", oOverrun, oCount);
    end
    iReady = 1'b1;
    for (int i = 0; i < 16; i++) begin
      checks++;
      if (oData !== 8'(i)) begin
        failures++;
        $display("FAIL overrun_data i=%0d data=%h want %h", i, oData, 8'(i));
      end
      tick();
    end
    iReady = 1'b0;
    checks++;
    if (oCount !== 5'd0 || oOverrun !== 1'b1) begin
      failures++;
      $display("FAIL overrun_sticky count=%0d ovr=%b want 0 1", oCount, oOverrun);
    end
    iClearFlags = 1'b1;
    tick();
    iClearFlags = 1'b0;
    checks++;
    if (oOverrun !== 1'b0) begin
      failures++;
      $display("FAIL overrun_clear ovr=%b want 0", oOverrun);
    end
    fill16(8'h00);
    iData = 8'hEE;
    iReceived = 1'b1;
    iReady = 1'b1;
    tick();
    iReceived = 1'b0;
    checks++;
    if (oOverrun !== 1'b0 || oCount !== 5'd16 || oData !== 8'h01) begin
      failures++;
      $display("FAIL full_push_pop ovr=%b count=%0d head=%h want 0 16 01",
               oOverrun, oCount, oData);
    end
    for (int i = 1; i < 17; i++) begin
      checks++;
      if (oValid !== 1'b1 || oData !== ((i == 16) ? 8'hEE : 8'(i))) begin
        failures++;
        $display("FAIL full_push_pop_order i=%0d data=%h want %h",
                 i, oData, (i == 16) ? 8'hEE : 8'(i));
      end
      tick();
    end
    iReady = 1'b0;
    checks++;
    if (oValid !== 1'b0 || oOverrun !== 1'b0) begin
      failures++;
      $display("FAIL full_push_pop_end valid=%b ovr=%b want 0 0", oValid, oOverrun);
    end
  endtask

  task automatic test_back_to_back();
    int outIdx;
    int budget;
    outIdx = 0;
    budget = 0;
    iReady = 1'b1;
    for (int i = 0; i < 48; i++) begin
      iData = 8'h40 + 8'(i);
      iReceived = 1'b1;
      tick();
      checks++;
      if (oCount > 5'd2 || oValid !== 1'b1 || oData !== 8'h40 + 8'(outIdx)) begin
        failures++;
        $display("FAIL stream i=%0d count=%0d valid=%b data=%h want <=2 1 %h",
                 i, oCount, oValid, oData, 8'h40 + 8'(outIdx));
      end
      outIdx++;
    end
    iReceived = 1'b0;
    while (oValid === 1'b1 && budget < 8) begin
      tick();
      budget++;
    end
    checks++;
    if (oValid !== 1'b0 || oCount !== 5'd0 || outIdx != 48) begin
      failures++;
      $display("FAIL stream_end valid=%b count=%0d out=%0d want 0 0 48",
               oValid, oCount, outIdx);
    end
    iReady = 1'b0;
  endtask

  task automatic test_errors();
    iError = 1'b1;
    for (int i = 0; i < 300; i++) begin
      tick();
    end
    iError = 1'b0;
    checks++;
    if (oErrorCount !== 8'd255) begin
      failures++;
      $display("FAIL err_saturate count=%0d want 255", oErrorCount);
    end
    iError = 1'b1;
    iClearFlags = 1'b1;
    tick();
    iError = 1'b0;
    iClearFlags = 1'b0;
    checks++;
    if (oErrorCount !== 8'd1) begin
      failures++;
      $display("FAIL err_clear_race count=%0d want 1", oErrorCount);
    end
    iError = 1'b1;
    iData = 8'h3C;
    iReceived = 1'b1;
    tick();
    iError = 1'b0;
    iReceived = 1'b0;
    checks++;
    if (oErrorCount !== 8'd2 || oData !== 8'h3C || oCount !== 5'd1) begin
      failures++;
      $display("FAIL err_with_rx err=%0d data=%h count=%0d want 2 3c 1",
               oErrorCount, oData, oCount);
    end
    iClearFlags = 1'b1;
    tick();
    iClearFlags = 1'b0;
    checks++;
    if (oErrorCount !== 8'd0 || oCount !== 5'd1 || oData !== 8'h3C) begin
      failures++;
      $display("FAIL err_clear err=%0d count=%0d data=%h want 0 1 3c",
               oErrorCount, oCount, oData);
    end
    iReady = 1'b1;
    tick();
    iReady = 1'b0;
  endtask

  task automatic test_async_reset();
    iReady = 1'b0;
    for (int i = 0; i < 5; i++) begin
      iData = 8'h90 + 8'(i);
      iReceived = 1'b1;
      tick();
    end
    iReceived = 1'b0;
    iError = 1'b1;
    tick();
    iError = 1'b0;
    checks++;
    if (oCount !== 5'd5 || oData !== 8'h90 || oErrorCount !== 8'd1) begin
      failures++;
      $display("FAIL pre_reset count=%0d data=%h err=%0d want 5 90 1",
               oCount, oData, oErrorCount);
    end
    #2;
    iReset_n = 1'b0;
    #1;
    checks++;
    if (oValid !== 1'b0 || oCount !== 5'd0 || oData !== 8'h00 ||
        oErrorCount !== 8'd0 || oAlmostFull !== 1'b0) begin
      failures++;
      $display("FAIL async_reset valid=%b count=%0d data=%h err=%0d af=%b want 0 0 00 0 0",
               oValid, oCount, oData, oErrorCount, oAlmostFull);
    end
    tick();
    iReset_n = 1'b1;
    tick();
    iData = 8'h77;
    iReceived = 1'b1;
    tick();
    iReceived = 1'b0;
    checks++;
    if (oValid !== 1'b1 || oData !== 8'h77 || oCount !== 5'd1) begin
      failures++;
      $display("FAIL after_reset valid=%b data=%h count=%0d want 1 77 1",
               oValid, oData, oCount);
    end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    test_reset();
    test_single();
    test_fill_drain();
    test_overrun();
    test_back_to_back();
    test_errors();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
